fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 133 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Takes bytes from an upstream show-ahead FIFO and transmits each one as an
// 8N1 (or 8N2) UART frame: a start bit, eight data bits sent LSB first, then
// STOP_BITS stop bits. Every bit is held for CLKS_PER_BIT clock cycles.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk         clock, rising edge active
//   rst         asynchronous reset, active low
//   enable      1 = a new byte may be fetched while idle
//   fifo_empty  upstream FIFO empty flag
//   fifo_data   upstream FIFO head byte, valid whenever fifo_empty = 0
//   fifo_get    one-cycle pop strobe to the upstream FIFO
//   tx          registered serial output, idle high
//   busy        1 while a frame is in progress
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_get,
    output logic       tx,
    output logic       busy
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] baud_q,  baud_d;
    logic [2:0]  bit_q,   bit_d;    // data bit index in DATA, stop bit index in STOP
    logic [7:0]  shift_q, shift_d;
    logic        tx_q,    tx_d;
    logic        bit_end;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_get = 1'b0;
        tx_d     = 1'b1;

        bit_end = (baud_q == BAUD_LAST);
        // The baud counter runs only inside a frame and restarts at every bit boundary.
        baud_d  = (state_q == IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;

        case (state_q)
            IDLE: begin
                // fifo_get is combinational so the pop and the capture share one
                // edge; gating with rst keeps the strobe low while reset is held.
                if (rst && enable && !fifo_empty) begin
                    fifo_get = 1'b1;
                    shift_d  = fifo_data;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;     // wraps to 0 after bit 7, ready for STOP
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = IDLE;
                        bit_d   = 3'd0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // tx is registered from the next state so it changes exactly with the
        // state and never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Two instances: u_dut (CLKS_PER_BIT=4, STOP_BITS=1) and u_dut2
// (CLKS_PER_BIT=4, STOP_BITS=2). Each is fed by a queue acting as the
// upstream FIFO. The reference model keeps, per lane, the queue of tx levels
// still owed for the current frame; when that queue is empty the lane is
// idle. A fetch loads the whole expected waveform of the frame at once.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable,  fifo_empty,  fifo_get,  tx,  busy;
    logic       enable2, fifo_empty2, fifo_get2, tx2, busy2;
    logic [7:0] fifo_data, fifo_data2;

    always #5 clk = ~clk;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_get   (fifo_get),
        .tx         (tx),
        .busy       (busy)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable2),
        .fifo_empty (fifo_empty2),
        .fifo_data  (fifo_data2),
        .fifo_get   (fifo_get2),
        .tx         (tx2),
        .busy       (busy2)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         busy_cnt, busy2_cnt, get2_cnt;
    int         get_cyc[$];
    logic       last_get;
    logic [7:0] fq[$];
    logic [7:0] fq2[$];
    bit         exp_q[$];
    bit         exp2_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Expected tx level of every cycle of a frame: start slot, eight data
    // slots LSB first, then sb stop slots, each CPB cycles long.
    function automatic void load_frame(input logic [7:0] b, input int sb, input int lane);
        bit v;
        for (int i = 0; i < (9 + sb) * CPB; i++) begin
            int slot;
            slot = i / CPB;
            if (slot == 0)      v = 1'b0;
            else if (slot <= 8) v = b[slot-1];
            else                v = 1'b1;
            if (lane == 0) exp_q.push_back(v);
            else           exp2_q.push_back(v);
        end
    endfunction

    task automatic drive_fifo();
        fifo_empty  = (fq.size() == 0);
        fifo_data   = fifo_empty  ? 8'($urandom) : fq[0];
        fifo_empty2 = (fq2.size() == 0);
        fifo_data2  = fifo_empty2 ? 8'($urandom) : fq2[0];
    endtask

    // One clock cycle: compare outputs at the falling edge, advance the
    // model, then let the FIFOs react to the pops just after the rising edge.
    task automatic tick();
        bit   e_tx, e_busy, e_get, e2_tx, e2_busy, e2_get;
        logic a_get, a_get2;
        @(negedge clk);
        if (!rst) begin
            exp_q.delete();
            exp2_q.delete();
        end
        e_busy  = (exp_q.size() != 0);
        e_tx    = e_busy ? exp_q[0] : 1'b1;
        e_get   = rst && !e_busy && enable && (fq.size() != 0);
        e2_busy = (exp2_q.size() != 0);
        e2_tx   = e2_busy ? exp2_q[0] : 1'b1;
        e2_get  = rst && !e2_busy && enable2 && (fq2.size() != 0);
        check("tx",    tx,        e_tx);
        check("busy",  busy,      e_busy);
        check("get",   fifo_get,  e_get);
        check("tx2",   tx2,       e2_tx);
        check("busy2", busy2,     e2_busy);
        check("get2",  fifo_get2, e2_get);
        a_get    = fifo_get;
        a_get2   = fifo_get2;
        last_get = a_get;
        if (a_get)  get_cyc.push_back(cyc);
        if (busy)   busy_cnt++;
        if (a_get2) get2_cnt++;
        if (busy2)  busy2_cnt++;
        if (e_get)       load_frame(fq[0], 1, 0);
        else if (e_busy) void'(exp_q.pop_front());
        if (e2_get)       load_frame(fq2[0], 2, 1);
        else if (e2_busy) void'(exp2_q.pop_front());
        @(posedge clk);
        #1;
        cyc++;
        if (a_get && fq.size() != 0)   void'(fq.pop_front());
        if (a_get2 && fq2.size() != 0) void'(fq2.pop_front());
        drive_fifo();
    endtask

    task automatic wait_get();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!last_get && n < 100);
        check("wait_get", last_get, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst     = 1'b0;
        enable  = 1'b1;
        enable2 = 1'b1;
        fq.push_back(8'hA5);
        drive_fifo();

        // Reset held with a byte available and enable high: nothing fetched.
        repeat (5) tick();
        check("rst_nofetch", fq.size(), 1);

        // Release: the waiting 0xA5 goes out as one 40-cycle frame.
        rst = 1'b1;
        get_cyc.delete();
        busy_cnt = 0;
        repeat (46) tick();
        check("a5_gets", get_cyc.size(), 1);
        check("a5_busy", busy_cnt, 40);

        // Back-to-back 0x00 / 0xFF from a pre-filled FIFO.
        enable = 1'b0;
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        drive_fifo();
        tick();
        enable = 1'b1;
        get_cyc.delete();
        repeat (90) tick();
        check("b2b_gets", get_cyc.size(), 2);
        if (get_cyc.size() >= 2) check("b2b_gap", get_cyc[1] - get_cyc[0], 41);

        // enable dropped mid-frame: frame completes, next fetch waits.
        fq.push_back(8'h3C);
        fq.push_back(8'h11);
        drive_fifo();
        wait_get();
        repeat (9) tick();
        enable = 1'b0;
        repeat (50) tick();
        check("en_hold", fq.size(), 1);
        enable = 1'b1;
        repeat (46) tick();
        check("en_drain", fq.size(), 0);

        // Reset during data bit 3: frame aborted, popped byte dropped.
        fq.push_back(8'h5A);
        fq.push_back(8'h96);
        drive_fifo();
        wait_get();
        repeat (18) tick();
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("rst_tx",     tx,        1'b1);
        check("rst_busy",   busy,      1'b0);
        check("rst_get",    fifo_get,  1'b0);
        check("rst_popped", fq.size(), 1);
        tick();
        rst = 1'b1;
        get_cyc.delete();
        repeat (46) tick();
        check("post_rst_gets",  get_cyc.size(), 1);
        check("post_rst_drain", fq.size(), 0);

        // Randomized bytes, FIFO gaps and enable toggles.
        repeat (400) begin
            if ($urandom_range(0, 3) == 0 && fq.size() < 4) begin
                fq.push_back(8'($urandom));
                drive_fifo();
            end
            enable = ($urandom_range(0, 9) != 0);
            tick();
        end
        enable = 1'b1;
        repeat (200) tick();
        check("rand_drain", fq.size(), 0);

        // Two stop bits: the second lane has sat idle with an empty FIFO.
        check("sb2_idle_get", get2_cnt, 0);
        get2_cnt  = 0;
        busy2_cnt = 0;
        fq2.push_back(8'h81);
        drive_fifo();
        repeat (55) tick();
        check("sb2_gets", get2_cnt, 1);
        check("sb2_busy", busy2_cnt, 44);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
